operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
- Parametrised successor to the team's fixed four-operand capture/compute block.
- Collects NUM_SLOTS operands of DATA_W bits into addressed slots and, once every slot is filled, computes a mode-selected reduction over them.
- Holds the result under a valid/ready handshake, then clears all slots for the next operand set.
- Sits between the operand entry path (switches/bus writes) and downstream result consumers.

Parameters:
NUM_SLOTS, 4, number of operand slots (2..16)
DATA_W, 4, operand width in bits
SEL_W, $clog2(NUM_SLOTS), slot select width (derived, not overridden)
RES_W, DATA_W+$clog2(NUM_SLOTS), result width; sum cannot overflow

Ports:
clock  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
d_in  input  DATA_W  operand data
slot_sel  input  SEL_W  target slot for capture
capture  input  1  write d_in into slot_sel this cycle
op_mode  input  2  reduction select: 0 SUM, 1 MAX, 2 MIN, 3 XOR
result  output  RES_W  reduction result, zero-extended for MAX/MIN/XOR
result_valid  output  1  result held and valid
result_ready  input  1  consumer accepts result
slot_valid  output  NUM_SLOTS  per-slot filled flags
busy  output  1  high in CALC or HOLD; captures not accepted
cap_err  output  1  one-cycle pulse on a rejected or overwriting capture

Behaviour:
- Reset (async, rst=1):
  - state=COLLECT; all slot data and slot_valid cleared.
  - result=0, result_valid=0, busy=0, cap_err=0.
  - Applies immediately, including mid-CALC/HOLD; a pending result is discarded.
- COLLECT:
  - capture=1 with slot_sel<NUM_SLOTS: slot data<=d_in, slot_valid[sel]<=1 at the clock edge.
  - Capture to an already-valid slot overwrites it and pulses cap_err the next cycle.
  - slot_sel>=NUM_SLOTS (non-power-of-2 NUM_SLOTS only): write ignored, cap_err pulses.
  - Transition to CALC on the edge where slot_valid becomes all-ones. op_mode is sampled on that same edge and stored as mode_q.
- CALC (exactly 1 cycle):
  - result<=reduce(mode_q, slots) registered; go to HOLD.
  - SUM is an unsigned full-width add. MAX/MIN are unsigned compares. XOR is bitwise over DATA_W.
- HOLD:
  - result_valid=1; result stable until the handshake.
  - On an edge with result_valid & result_ready: result_valid<=0, all slot_valid<=0, state<=COLLECT. result keeps its last value.
- busy=1 in CALC and HOLD. Any capture while busy is ignored and pulses cap_err, including a capture in the handshake cycle.
- Latency: final capture at edge k → result_valid high after edge k+1. The earliest next capture is accepted at the edge after the handshake edge.
- result_ready outside HOLD has no effect.
- cap_err is registered, high for exactly one cycle per offending capture, and never sticky.
- The slot_valid output mirrors internal flags with no added delay.

Decomposition:
- Package operand_collector_pkg:
  - mode enum (MODE_SUM=2'd0, MODE_MAX=2'd1, MODE_MIN=2'd2, MODE_XOR=2'd3).
  - state enum (COLLECT, CALC, HOLD).
  - function res_width(num_slots, data_w).
- Sub-module operand_slot: DATA_W register plus valid flag with write enable, clear, and async active-high reset. It is instantiated NUM_SLOTS times via generate.
- The reduction is a combinational loop in the top; the FSM and handshake also live in the top.

Test Plan:
- Default params, SUM: capture 15,15,15,15 into slots 0..3 with op_mode=0 on the last capture → result_valid after 1 cycle, result=60 (6'b111100).
- MAX/MIN: operands 3,9,1,7 with op_mode=1 → result=9; repeat with op_mode=2 → result=1. Also change op_mode during HOLD → result unchanged.
- Overwrite: slot 2 written 5 then 8, fill the rest with 0, SUM → cap_err one pulse, result=8.
- Backpressure: result_ready=0 for 10 cycles in HOLD while capture=1 each cycle → result stable, 10 cap_err pulses, slot_valid stays 4'b1111. Raise result_ready → slots clear next edge, busy=0.
- Reset mid-operation: assert rst asynchronously (between edges) with 3 slots filled, and again in HOLD → outputs zero immediately, state COLLECT, no result_valid after release.
- NUM_SLOTS=3, DATA_W=8, XOR: 0xA5,0x0F,0xFF → result=0x55 (RES_W=10). A capture with slot_sel=3 → ignored and cap_err pulses.

Source files
------------

// File: rtl/operand_collector_pkg.sv
// Shared types and helpers for the operand collector.
package operand_collector_pkg;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_MAX = 2'd1,
    MODE_MIN = 2'd2,
    MODE_XOR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Result width wide enough that a full sum of all slots cannot overflow.
  function automatic int unsigned res_width(input int unsigned num_slots,
                                            input int unsigned data_w);
    return data_w + $clog2(num_slots);
  endfunction

endpackage

// File: rtl/operand_slot.sv
// One operand slot: data register plus filled flag.
module operand_slot #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              we,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // Clear wins over write; the collector never asserts both together.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (we) begin
      data  <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/operand_collector.sv
// Collects NUM_SLOTS operands, reduces them once full, holds the result
// under valid/ready, then clears the slots for the next set.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS = 4,
  parameter  int unsigned DATA_W    = 4,
  localparam int unsigned SEL_W     = $clog2(NUM_SLOTS),
  localparam int unsigned RES_W     = res_width(NUM_SLOTS, DATA_W)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    d_in,
  input  logic [SEL_W-1:0]     slot_sel,
  input  logic                 capture,
  input  logic [1:0]           op_mode,
  output logic [RES_W-1:0]     result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 busy,
  output logic                 cap_err
);

  state_e                           state;
  state_e                           state_next;
  mode_e                            mode_q;
  mode_e                            mode_next;
  logic [RES_W-1:0]                 result_next;
  logic [RES_W-1:0]                 red;
  logic [RES_W-1:0]                 red_sum;
  logic [DATA_W-1:0]                red_max;
  logic [DATA_W-1:0]                red_min;
  logic [DATA_W-1:0]                red_xor;
  logic                             cap_err_next;
  logic                             sel_ok;
  logic                             slot_clr;
  logic [NUM_SLOTS-1:0]             sel_onehot;
  logic [NUM_SLOTS-1:0]             slot_we;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] slot_data;

  // Slot select decode; out-of-range selects exist only for non-power-of-2 counts.
  assign sel_ok     = (32'(slot_sel) < NUM_SLOTS);
  assign sel_onehot = NUM_SLOTS'(1) << slot_sel;

  // Operand slot storage.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    operand_slot #(.DATA_W(DATA_W)) u_slot (
      .clock (clock),
      .rst   (rst),
      .we    (slot_we[g]),
      .clr   (slot_clr),
      .d     (d_in),
      .data  (slot_data[g]),
      .valid (slot_valid[g])
    );
  end

  // Mode-selected reduction over all slots; MAX/MIN/XOR are zero-extended.
  always_comb begin
    red_sum = '0;
    red_max = '0;
    red_min = '1;
    red_xor = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      red_sum = red_sum + RES_W'(slot_data[i]);
      if (slot_data[i] > red_max) red_max = slot_data[i];
      if (slot_data[i] < red_min) red_min = slot_data[i];
      red_xor = red_xor ^ slot_data[i];
    end
    red = red_sum;
    case (mode_q)
      MODE_SUM: red = red_sum;
      MODE_MAX: red = RES_W'(red_max);
      MODE_MIN: red = RES_W'(red_min);
      MODE_XOR: red = RES_W'(red_xor);
      default:  red = red_sum;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // Next state, slot control and next output values.
  always_comb begin
    state_next   = state;
    mode_next    = mode_q;
    result_next  = result;
    cap_err_next = 1'b0;
    slot_we      = '0;
    slot_clr     = 1'b0;
    case (state)
      COLLECT: begin
        if (capture) begin
          if (sel_ok) begin
            slot_we      = sel_onehot;
            cap_err_next = |(slot_valid & sel_onehot);
          end else begin
            cap_err_next = 1'b1;
          end
        end
        if (&(slot_valid | slot_we)) begin
          state_next = CALC;
          mode_next  = mode_e'(op_mode);
        end
      end
      CALC: begin
        cap_err_next = capture;
        result_next  = red;
        state_next   = HOLD;
      end
      HOLD: begin
        cap_err_next = capture;
        if (result_ready) begin
          slot_clr   = 1'b1;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Registered outputs and captured mode.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_SUM;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      cap_err      <= 1'b0;
    end else begin
      mode_q       <= mode_next;
      result       <= result_next;
      result_valid <= (state_next == HOLD);
      busy         <= (state_next != COLLECT);
      cap_err      <= cap_err_next;
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: directed scenarios plus randomized sets
// checked against a transaction-level reduction model.
module tb_operand_collector;

  logic clock = 1'b0;
  logic rst;

  always #5 clock = ~clock;

  // Default-parameter instance (4 slots x 4 bits).
  logic [3:0] d_in;
  logic [1:0] slot_sel;
  logic       capture;
  logic [1:0] op_mode;
  logic       result_ready;
  logic [5:0] result;
  logic       result_valid;
  logic [3:0] slot_valid;
  logic       busy;
  logic       cap_err;

  // Three-slot, eight-bit instance.
  logic [7:0] d3;
  logic [1:0] sel3;
  logic       cap3;
  logic [1:0] mode3;
  logic       ready3;
  logic [9:0] res3;
  logic       rv3;
  logic [2:0] sv3;
  logic       busy3;
  logic       err3;

  int vectors = 0;
  int miscompares = 0;

  operand_collector dut (
    .clock        (clock),
    .rst          (rst),
    .d_in         (d_in),
    .slot_sel     (slot_sel),
    .capture      (capture),
    .op_mode      (op_mode),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .slot_valid   (slot_valid),
    .busy         (busy),
    .cap_err      (cap_err)
  );

  operand_collector #(.NUM_SLOTS(3), .DATA_W(8)) dut3 (
    .clock        (clock),
    .rst          (rst),
    .d_in         (d3),
    .slot_sel     (sel3),
    .capture      (cap3),
    .op_mode      (mode3),
    .result       (res3),
    .result_valid (rv3),
    .result_ready (ready3),
    .slot_valid   (sv3),
    .busy         (busy3),
    .cap_err      (err3)
  );

  // Reference reduction computed from plain integer arithmetic.
  function automatic int ref_reduce(input int mode, input int vals[4]);
    int acc;
    case (mode)
      0: begin acc = 0;  foreach (vals[i]) acc = acc + vals[i]; end
      1: begin acc = 0;  foreach (vals[i]) if (vals[i] > acc) acc = vals[i]; end
      2: begin acc = 15; foreach (vals[i]) if (vals[i] < acc) acc = vals[i]; end
      default: begin acc = 0; foreach (vals[i]) acc = acc ^ vals[i]; end
    endcase
    return acc;
  endfunction

  // Drive one capture cycle; returns at the negedge after the capturing edge.
  task automatic cap(input int d, input int s, input int m);
    d_in     = 4'(d);
    slot_sel = 2'(s);
    op_mode  = 2'(m);
    capture  = 1'b1;
    @(negedge clock);
    capture  = 1'b0;
  endtask

  // One-cycle handshake in HOLD.
  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({result, result_valid, slot_valid, busy, cap_err} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got res=%0d rv=%b sv=%b busy=%b err=%b want all zero",
               result, result_valid, slot_valid, busy, cap_err);
    end
    vectors++;
    if ({res3, rv3, sv3, busy3, err3} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs3: got res=%0d rv=%b sv=%b want all zero", res3, rv3, sv3);
    end
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_sum();
    do_reset();
    cap(15, 0, 3);
    cap(15, 1, 3);
    cap(15, 2, 3);
    cap(15, 3, 0);
    vectors++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sum_calc_cycle: got busy=%b rv=%b want busy=1 rv=0", busy, result_valid);
    end
    @(negedge clock);
    vectors++;
    if (result_valid !== 1'b1 || result !== 6'd60) begin
      miscompares++;
      $display("FAIL sum_result: got rv=%b res=%0d want rv=1 res=60", result_valid, result);
    end
    handshake();
    vectors++;
    if (result_valid !== 1'b0 || slot_valid !== 4'b0000 || busy !== 1'b0 || result !== 6'd60) begin
      miscompares++;
      $display("FAIL sum_release: got rv=%b sv=%b busy=%b res=%0d want 0 0000 0 60",
               result_valid, slot_valid, busy, result);
    end
  endtask

  task automatic test_max_min();
    do_reset();
    cap(3, 0, 2); cap(9, 1, 2); cap(1, 2, 2); cap(7, 3, 1);
    @(negedge clock);
    vectors++;
    if (result !== 6'd9) begin
      miscompares++;
      $display("FAIL max_result: got %0d want 9", result);
    end
    op_mode = 2'd2;
    repeat (2) @(negedge clock);
    vectors++;
    if (result !== 6'd9 || result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL max_mode_change_hold: got res=%0d rv=%b want 9 1", result, result_valid);
    end
    handshake();
    cap(3, 0, 1); cap(9, 1, 1); cap(1, 2, 1); cap(7, 3, 2);
    @(negedge clock);
    vectors++;
    if (result !== 6'd1) begin
      miscompares++;
      $display("FAIL min_result: got %0d want 1", result);
    end
    handshake();
  endtask

  task automatic test_overwrite();
    do_reset();
    cap(5, 2, 0);
    vectors++;
    if (cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovw_first_write: got cap_err=%b want 0", cap_err);
    end
    cap(8, 2, 0);
    vectors++;
    if (cap_err !== 1'b1 || slot_valid !== 4'b0100) begin
      miscompares++;
      $display("FAIL ovw_pulse: got cap_err=%b sv=%b want 1 0100", cap_err, slot_valid);
    end
    cap(0, 0, 0);
    vectors++;
    if (cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovw_not_sticky: got cap_err=%b want 0", cap_err);
    end
    cap(0, 1, 0); cap(0, 3, 0);
    @(negedge clock);
    vectors++;
    if (result !== 6'd8 || result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovw_result: got res=%0d rv=%b want 8 1", result, result_valid);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    do_reset();
    cap(1, 0, 0); cap(2, 1, 0); cap(3, 2, 0); cap(4, 3, 0);
    @(negedge clock);
    capture = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_in     = 4'($urandom_range(15, 0));
      slot_sel = 2'($urandom_range(3, 0));
      @(negedge clock);
      if (cap_err === 1'b1) pulses++;
      vectors++;
      if (result !== 6'd10 || result_valid !== 1'b1 || slot_valid !== 4'b1111 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold_stable[%0d]: got res=%0d rv=%b sv=%b busy=%b want 10 1 1111 1",
                 i, result, result_valid, slot_valid, busy);
      end
    end
    vectors++;
    if (pulses != 10) begin
      miscompares++;
      $display("FAIL bp_err_pulses: got %0d want 10", pulses);
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    capture = 1'b0;
    vectors++;
    if (slot_valid !== 4'b0000 || busy !== 1'b0 || result_valid !== 1'b0 || cap_err !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got sv=%b busy=%b rv=%b err=%b want 0000 0 0 1",
               slot_valid, busy, result_valid, cap_err);
    end
    cap(6, 1, 0);
    vectors++;
    if (slot_valid !== 4'b0010 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next_capture: got sv=%b err=%b want 0010 0", slot_valid, cap_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cap(1, 0, 0); cap(2, 1, 0); cap(3, 2, 0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (slot_valid !== 4'b0000 || busy !== 1'b0 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_collect: got sv=%b busy=%b err=%b want 0000 0 0", slot_valid, busy, cap_err);
    end
    rst = 1'b0;
    @(negedge clock);
    cap(5, 3, 0);
    repeat (3) @(negedge clock);
    vectors++;
    if (result_valid !== 1'b0 || slot_valid !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_mid_after: got rv=%b sv=%b want 0 1000", result_valid, slot_valid);
    end
    cap(1, 0, 0); cap(1, 1, 0); cap(1, 2, 0);
    @(negedge clock);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (result_valid !== 1'b0 || result !== 6'd0 || busy !== 1'b0 || slot_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mid_hold: got rv=%b res=%0d busy=%b sv=%b want 0 0 0 0000",
               result_valid, result, busy, slot_valid);
    end
    rst = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_hold_release: got rv=%b busy=%b want 0 0", result_valid, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 30; it++) begin
      int vals[4];
      int order[4];
      int mode;
      int expv;
      logic [3:0] mask;
      order = '{0, 1, 2, 3};
      for (int i = 3; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(i, 0);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      mode = $urandom_range(3, 0);
      mask = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (k > 0 && $urandom_range(3, 0) == 0) begin
          int s;
          s = order[$urandom_range(k - 1, 0)];
          vals[s] = $urandom_range(15, 0);
          result_ready = 1'($urandom_range(1, 0));
          cap(vals[s], s, $urandom_range(3, 0));
          vectors++;
          if (cap_err !== 1'b1 || slot_valid !== mask) begin
            miscompares++;
            $display("FAIL rnd_overwrite[%0d]: got err=%b sv=%b want 1 %b", it, cap_err, slot_valid, mask);
          end
        end
        vals[order[k]] = $urandom_range(15, 0);
        mask[order[k]] = 1'b1;
        result_ready = 1'($urandom_range(1, 0));
        cap(vals[order[k]], order[k], (k == 3) ? mode : int'($urandom_range(3, 0)));
        vectors++;
        if (cap_err !== 1'b0 || slot_valid !== mask) begin
          miscompares++;
          $display("FAIL rnd_capture[%0d.%0d]: got err=%b sv=%b want 0 %b", it, k, cap_err, slot_valid, mask);
        end
      end
      result_ready = 1'b0;
      expv = ref_reduce(mode, vals);
      vectors++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_latency[%0d]: got busy=%b rv=%b want 1 0", it, busy, result_valid);
      end
      @(negedge clock);
      repeat ($urandom_range(3, 0)) @(negedge clock);
      vectors++;
      if (result_valid !== 1'b1 || result !== 6'(expv)) begin
        miscompares++;
        $display("FAIL rnd_result[%0d]: mode=%0d got rv=%b res=%0d want 1 %0d",
                 it, mode, result_valid, result, expv);
      end
      handshake();
      vectors++;
      if (slot_valid !== 4'b0000 || result_valid !== 1'b0 || result !== 6'(expv)) begin
        miscompares++;
        $display("FAIL rnd_release[%0d]: got sv=%b rv=%b res=%0d want 0000 0 %0d",
                 it, slot_valid, result_valid, result, expv);
      end
    end
  endtask

  task automatic cap3_drive(input int d, input int s, input int m);
    d3    = 8'(d);
    sel3  = 2'(s);
    mode3 = 2'(m);
    cap3  = 1'b1;
    @(negedge clock);
    cap3  = 1'b0;
  endtask

  task automatic test_three_slot_xor();
    do_reset();
    cap3_drive(8'h12, 3, 3);
    vectors++;
    if (err3 !== 1'b1 || sv3 !== 3'b000) begin
      miscompares++;
      $display("FAIL n3_bad_sel: got err=%b sv=%b want 1 000", err3, sv3);
    end
    cap3_drive(8'hA5, 0, 0);
    cap3_drive(8'h0F, 1, 0);
    cap3_drive(8'hFF, 2, 3);
    @(negedge clock);
    vectors++;
    if (rv3 !== 1'b1 || res3 !== 10'h055) begin
      miscompares++;
      $display("FAIL n3_xor_result: got rv=%b res=%h want 1 055", rv3, res3);
    end
    ready3 = 1'b1;
    @(negedge clock);
    ready3 = 1'b0;
    vectors++;
    if (sv3 !== 3'b000 || busy3 !== 1'b0) begin
      miscompares++;
      $display("FAIL n3_release: got sv=%b busy=%b want 000 0", sv3, busy3);
    end
  endtask

  initial begin
    rst          = 1'b1;
    d_in         = '0;
    slot_sel     = '0;
    capture      = 1'b0;
    op_mode      = '0;
    result_ready = 1'b0;
    d3           = '0;
    sel3         = '0;
    cap3         = 1'b0;
    mode3        = '0;
    ready3       = 1'b0;
    test_reset();
    test_sum();
    test_max_min();
    test_overwrite();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_three_slot_xor();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
